lcd_write_scheduler: RTL



---
 rtl/lcd_write_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/lcd_write_scheduler.sv
// Round-robin write scheduler for a shared HD44780 1602 LCD bus with RS/EN/DATA timing.
// Optional power-up init sequence (0x38, 0x0C, 0x01, 0x06) when LCD_SCHED_INIT_EN is defined.
module lcd_write_scheduler #(
  parameter int SETUP_CYC     = 2,
  parameter int EN_HIGH_CYC   = 23,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 82000,
  parameter int POWERUP_CYC   = 750000
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       ireq0_valid,
  input  logic [8:0] ireq0_word,
  output logic       oreq0_ready,
  input  logic       ireq1_valid,
  input  logic [8:0] ireq1_word,
  output logic       oreq1_ready,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       obusy,
  output logic       odone
);

  localparam int MAX_A   = (LONG_EXEC_CYC > POWERUP_CYC) ? LONG_EXEC_CYC : POWERUP_CYC;
  localparam int CNT_MAX = (MAX_A > EXEC_CYC) ? MAX_A : EXEC_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] LEXEC_LD = CW'(LONG_EXEC_CYC - 1);
  localparam logic [CW-1:0] PWR_LD   = CW'(POWERUP_CYC - 1);

  typedef enum logic [2:0] {IDLE, INIT_WAIT, SETUP, EN_HI, HOLD, EXEC} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          idle;
  logic          pick1;
  logic [CW-1:0] exec_ld;

`ifdef LCD_SCHED_INIT_EN
  logic       init_active;
  logic [1:0] init_idx;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction
`else
  localparam logic init_active = 1'b0;
`endif

  // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
  assign idle        = (state == IDLE);
  assign pick1       = ireq1_valid && (!ireq0_valid || !last);
  assign oreq1_ready = idle && pick1;
  assign oreq0_ready = idle && ireq0_valid && !pick1;
  assign LCD_RW      = 1'b0;

  // Clear and Return Home need the long controller execution time.
  always_comb begin
    exec_ld = EXEC_LD;
    if (!LCD_RS && (LCD_DATA inside {8'h01, 8'h02, 8'h03}))
      exec_ld = LEXEC_LD;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      LCD_EN   <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= 8'h00;
      odone    <= 1'b0;
      last     <= 1'b1;
`ifdef LCD_SCHED_INIT_EN
      state       <= INIT_WAIT;
      cnt         <= PWR_LD;
      obusy       <= 1'b1;
      init_active <= 1'b1;
      init_idx    <= 2'd0;
`else
      state <= IDLE;
      cnt   <= '0;
      obusy <= 1'b0;
`endif
    end else begin
      odone <= 1'b0;
      case (state)
        IDLE: begin
          if (oreq0_ready || oreq1_ready) begin
            {LCD_RS, LCD_DATA} <= pick1 ? ireq1_word : ireq0_word;
            last  <= pick1;
            state <= SETUP;
            cnt   <= SETUP_LD;
            obusy <= 1'b1;
          end
        end
`ifdef LCD_SCHED_INIT_EN
        INIT_WAIT: begin
          if (cnt == '0) begin
            LCD_RS   <= 1'b0;
            LCD_DATA <= init_cmd(init_idx);
            state    <= SETUP;
            cnt      <= SETUP_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        SETUP: begin
          if (cnt == '0) begin
            state  <= EN_HI;
            LCD_EN <= 1'b1;
            cnt    <= EN_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EN_HI: begin
          if (cnt == '0) begin
            state  <= HOLD;
            LCD_EN <= 1'b0;
            cnt    <= HOLD_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= EXEC;
            cnt   <= exec_ld;
            odone <= (exec_ld == '0) && !init_active;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
`ifdef LCD_SCHED_INIT_EN
            if (init_active && init_idx != 2'd3) begin
              init_idx <= init_idx + 2'd1;
              LCD_RS   <= 1'b0;
              LCD_DATA <= init_cmd(init_idx + 2'd1);
              state    <= SETUP;
              cnt      <= SETUP_LD;
            end else begin
              init_active <= 1'b0;
              state       <= IDLE;
              obusy       <= 1'b0;
            end
`else
            state <= IDLE;
            obusy <= 1'b0;
`endif
          end else begin
            cnt   <= cnt - 1'b1;
            // odone is registered, so raise it one edge ahead of the final EXEC cycle.
            odone <= (cnt == CW'(1)) && !init_active;
          end
        end
        default: begin
          state <= IDLE;
          obusy <= 1'b0;
        end
      endcase
    end
  end

endmodule
